// File: rtl/ps2_host_tx_if.sv
// Command-byte request/status bundle between the PS/2 host transmitter and its user.
// master = command issuer, slave = transmitter.
`timescale 1ns/1ps
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err_noack;
    logic       err_timeout;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, err_noack, err_timeout
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, err_noack, err_timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clocked shift-out
// of data/parity/stop, ACK sampling, with a watchdog over the device-clocked phase.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int START_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic         clk,
    input  logic         rstn,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int WD_W    = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE} state_t;

    state_t           state, state_nxt;
    logic             clk_meta, clk_s, clk_d, data_meta, data_s;
    logic             fall, line_idle, in_xfer, wd_hit, accept, shift_fall;
    logic [CNT_W-1:0] cnt;
    logic [WD_W-1:0]  wd;
    logic [3:0]       bit_cnt;
    logic [9:0]       sr;
    logic             data_q, ack_ok;
    logic             done_q, noack_q, tout_q;
    logic             done_set, noack_set, tout_set;

    assign fall       = clk_d & ~clk_s;
    assign line_idle  = clk_s & data_s;
    assign in_xfer    = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
    assign wd_hit     = in_xfer && (wd == WD_W'(TIMEOUT_CYCLES - 1));
    assign accept     = (state == IDLE) && tx.tx_valid && tx.tx_ready;
    assign shift_fall = (state == SHIFT) && fall && !wd_hit;

    // Pin synchronizers plus one extra clock-pin stage for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_meta  <= 1'b0;
            clk_s     <= 1'b0;
            clk_d     <= 1'b0;
            data_meta <= 1'b0;
            data_s    <= 1'b0;
        end else begin
            clk_meta  <= ps2_clk;
            clk_s     <= clk_meta;
            clk_d     <= clk_s;
            data_meta <= ps2_data;
            data_s    <= data_meta;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = INHIBIT;
            INHIBIT:   if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) state_nxt = START;
            START:     if (cnt == CNT_W'(START_CYCLES - 1)) state_nxt = SHIFT;
            SHIFT:     if (wd_hit) state_nxt = IDLE;
                       else if (fall && bit_cnt == 4'd9) state_nxt = ACK;
            ACK:       if (wd_hit) state_nxt = IDLE;
                       else if (fall) state_nxt = WAIT_IDLE;
            WAIT_IDLE: if (wd_hit || line_idle) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Ready is withheld during the status pulse so a held request starts one cycle later
    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx.tx_ready = 1'b0;
        done_set    = 1'b0;
        noack_set   = 1'b0;
        case (state)
            IDLE:      tx.tx_ready = ~(done_q | noack_q | tout_q);
            INHIBIT:   ps2_clk_oe  = 1'b1;
            START: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
            end
            SHIFT:     ps2_data_oe = data_q;
            WAIT_IDLE: begin
                done_set  = !wd_hit && line_idle && ack_ok;
                noack_set = !wd_hit && line_idle && !ack_ok;
            end
            default: ;
        endcase
        tout_set       = wd_hit;
        tx.busy        = (state != IDLE);
        tx.done        = done_q;
        tx.err_noack   = noack_q;
        tx.err_timeout = tout_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            wd      <= '0;
            bit_cnt <= '0;
            sr      <= '0;
            data_q  <= 1'b0;
            ack_ok  <= 1'b0;
            done_q  <= 1'b0;
            noack_q <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            done_q  <= done_set;
            noack_q <= noack_set;
            tout_q  <= tout_set;

            if (state_nxt != state)
                cnt <= '0;
            else if (state == INHIBIT || state == START)
                cnt <= cnt + CNT_W'(1);

            wd <= in_xfer ? wd + WD_W'(1) : '0;

            if (accept) begin
                sr      <= {1'b1, ~^tx.tx_data, tx.tx_data};
                bit_cnt <= '0;
            end else if (shift_fall) begin
                sr      <= {1'b0, sr[9:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end

            // Start bit stays driven from START into SHIFT until the first device fall
            if (state == START)
                data_q <= 1'b1;
            else if (shift_fall)
                data_q <= ~sr[0];
            else if (state != SHIFT)
                data_q <= 1'b0;

            if (state == ACK && fall && !wd_hit)
                ack_ok <= ~data_s;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx with a behavioural PS/2 device on open-drain pins.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH  = 100;
    localparam int STRT = 16;
    localparam int TO   = 20000;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic rstn;
    wire  ps2_clk, ps2_data;
    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low, dev_data_low;

    ps2_host_tx_if tx_if ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_CYCLES   (STRT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .tx          (tx_if),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    assign ps2_clk  = ~(ps2_clk_oe  | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    typedef struct {
        logic [9:0] frame;
        logic [2:0] pulses;
        string      name;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Device model: clocks out 11 falls, samples each host bit on the rising edge
    bit         dev_clocks = 1'b1;
    bit         dev_ack    = 1'b1;
    bit         dev_abort;
    int         dev_falls  = 0;
    logic [9:0] cap_bits;
    logic [9:0] cap_frame;

    task automatic dev_wait(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (!rstn) begin
                dev_abort = 1'b1;
                return;
            end
        end
    endtask

    initial begin : device
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        cap_frame    = 'x;
        forever begin
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
            dev_abort    = 1'b0;
            @(posedge clk);
            if (rstn && !ps2_clk_oe && ps2_data_oe) begin
                cap_frame = 'x;
                cap_bits  = 'x;
                dev_falls = 0;
                if (!dev_clocks) begin
                    while (rstn && ps2_data_oe) @(posedge clk);
                end else begin
                    for (int k = 1; k <= 11; k++) begin
                        if (k == 11) dev_data_low = dev_ack;
                        dev_wait(HALF);
                        if (dev_abort) break;
                        dev_clk_low = 1'b1;
                        dev_falls   = k;
                        dev_wait(HALF);
                        if (dev_abort) break;
                        dev_clk_low = 1'b0;
                        if (k <= 10) cap_bits[k-1] = ps2_data;
                        if (k == 10) cap_frame = cap_bits;
                        if (k == 11) dev_data_low = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: every status pulse retires one expected transfer
    always @(negedge clk) begin
        if (rstn && (tx_if.done || tx_if.err_noack || tx_if.err_timeout)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got done/noack/timeout=%b, required no pulse",
                         {tx_if.done, tx_if.err_noack, tx_if.err_timeout});
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_pulse"}, {29'd0, tx_if.done, tx_if.err_noack, tx_if.err_timeout},
                    {29'd0, mon_e.pulses});
                if (mon_e.pulses != 3'b001)
                    chk({mon_e.name, "_frame"}, {22'd0, cap_frame}, {22'd0, mon_e.frame});
            end
        end
    end

    task automatic push_exp(input logic [9:0] fr, input logic [2:0] pl, input string nm);
        exp_t e;
        e.frame  = fr;
        e.pulses = pl;
        e.name   = nm;
        exp_q.push_back(e);
    endtask

    task automatic wait_accept(input string nm);
        int n = 0;
        while (!tx_if.tx_ready && n < 50000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_accepted"}, {31'd0, tx_if.tx_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input string nm, output int shift_cycles);
        int n = 0;
        shift_cycles = 0;
        while (!(tx_if.done || tx_if.err_noack || tx_if.err_timeout) && n < 30000) begin
            if (tx_if.busy) shift_cycles++;
            @(negedge clk);
            n++;
        end
        chk({nm, "_finished"}, {31'd0, (n < 30000)}, 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic [9:0] fr, input logic [2:0] pl,
                        input string nm);
        int cnt;
        @(negedge clk);
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        push_exp(fr, pl, nm);
        wait_accept(nm);
        tx_if.tx_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_busy"}, {31'd0, tx_if.busy}, 32'd1);
        cnt = 0;
        while (ps2_clk_oe && !ps2_data_oe && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        chk({nm, "_inhibit_cycles"}, cnt, INH);
        cnt = 0;
        while (ps2_clk_oe && ps2_data_oe && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        chk({nm, "_start_cycles"}, cnt, STRT);
        chk({nm, "_start_bit"}, {31'd0, ps2_data_oe}, 32'd1);
        wait_pulse(nm, cnt);
        if (pl == 3'b001) chk({nm, "_shift_cycles"}, cnt, TO);
        chk({nm, "_oe_released"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk({nm, "_busy_low"}, {31'd0, tx_if.busy}, 32'd0);
        chk({nm, "_ready_in_pulse"}, {31'd0, tx_if.tx_ready}, 32'd0);
        @(negedge clk);
        chk({nm, "_ready_after"}, {31'd0, tx_if.tx_ready}, 32'd1);
    endtask

    initial begin : global_bound
        #1_000_000;
        $display("FAIL global_time_limit: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin : stimulus
        int cnt;
        rstn           = 1'b0;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk("reset_status", {28'd0, tx_if.busy, tx_if.done, tx_if.err_noack, tx_if.err_timeout}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("reset_ready", {31'd0, tx_if.tx_ready}, 32'd1);

        // LED-set, all ones, all zeros: parity of 0xED (6 ones) and 0xFF/0x00 is 1
        send(8'hED, 10'h3ED, 3'b100, "led_ed");
        send(8'hFF, 10'h3FF, 3'b100, "byte_ff");
        send(8'h00, 10'h300, 3'b100, "byte_00");

        // Device leaves data released in the ACK slot; 0xFE has 7 ones -> parity 0
        dev_ack = 1'b0;
        send(8'hFE, 10'h2FE, 3'b010, "noack_fe");
        dev_ack = 1'b1;

        // Device never clocks
        dev_clocks = 1'b0;
        send(8'hEE, 10'h000, 3'b001, "timeout");
        dev_clocks = 1'b1;
        repeat (5) @(negedge clk);

        // Request held high with new data during a transfer
        @(negedge clk);
        tx_if.tx_data  = 8'hEE;
        tx_if.tx_valid = 1'b1;
        push_exp(10'h3EE, 3'b100, "b2b_first");
        wait_accept("b2b_first");
        tx_if.tx_data = 8'h01;
        push_exp(10'h201, 3'b100, "b2b_second");
        wait_pulse("b2b_first", cnt);
        chk("b2b_ready_in_pulse", {31'd0, tx_if.tx_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_ready_next", {31'd0, tx_if.tx_ready}, 32'd1);
        chk("b2b_idle_next", {31'd0, tx_if.busy}, 32'd0);
        @(negedge clk);
        chk("b2b_second_busy", {31'd0, tx_if.busy}, 32'd1);
        chk("b2b_second_inhibit", {31'd0, ps2_clk_oe}, 32'd1);
        tx_if.tx_valid = 1'b0;
        @(negedge clk);
        wait_pulse("b2b_second", cnt);
        repeat (3) @(negedge clk);

        // Reset after the 4th fall of a 0x00 transfer: data pin is being pulled low
        @(negedge clk);
        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b1;
        wait_accept("abort");
        tx_if.tx_valid = 1'b0;
        cnt = 0;
        while (dev_falls != 4 && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        chk("abort_reached_fall4", dev_falls, 4);
        repeat (6) @(negedge clk);
        chk("abort_data_driven", {31'd0, ps2_data_oe}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("abort_oe_async", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk("abort_busy_async", {31'd0, tx_if.busy}, 32'd0);
        repeat (10) @(negedge clk);
        rstn = 1'b1;
        repeat (60) @(negedge clk);
        chk("abort_ready", {31'd0, tx_if.tx_ready}, 32'd1);
        chk("abort_idle", {31'd0, tx_if.busy}, 32'd0);

        // 0xA7 has 5 ones -> parity 0
        send(8'hA7, 10'h2A7, 3'b100, "after_reset_a7");

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
